// File: rtl/doorlock_pkg.sv
// ---------------------------------------------------------------------------
// doorlock_pkg
// Types and constants shared by the door-lock blocks.
//   digitos_t        four BCD digits; index 3 is the first digit entered
//   pinPac_t         assembled PIN: status (submitted/enabled) + digits
//   setupPac_t       stored configuration: master_pin, pin1..pin4
//   PIN_DIGITO_VAZIO blank-digit marker (never a valid stored digit)
//   slot_confere     slot match helper
// ---------------------------------------------------------------------------
package doorlock_pkg;

    localparam logic [3:0] PIN_DIGITO_VAZIO = 4'hE;

    typedef logic [3:0][3:0] digitos_t;

    typedef struct packed {
        logic     status;
        digitos_t digito;
    } pinPac_t;

    typedef struct packed {
        pinPac_t master_pin;
        pinPac_t pin1;
        pinPac_t pin2;
        pinPac_t pin3;
        pinPac_t pin4;
    } setupPac_t;

    // A slot matches when all four digits are equal and every stored digit
    // is a decimal digit; with exige_status set, the slot must also be enabled.
    function automatic logic slot_confere(input pinPac_t  guardado,
                                          input digitos_t digitado,
                                          input logic     exige_status);
        logic ok;
        ok = guardado.status | ~exige_status;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((guardado.digito[i] > 4'd9) || (guardado.digito[i] != digitado[i]))
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/gerador_tick.sv
// ---------------------------------------------------------------------------
// gerador_tick
// One-second prescaler: tick pulses for one cycle every CLK_FREQ_HZ cycles
// counted from the last cycle clear was high.
//   clk    system clock
//   rst    asynchronous, active-high reset
//   clear  holds the counter at zero (and suppresses tick)
//   tick   one-cycle pulse
// ---------------------------------------------------------------------------
module gerador_tick #(
    parameter int unsigned CLK_FREQ_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [W-1:0] ULTIMO = W'(CLK_FREQ_HZ - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clear || (r_cnt == ULTIMO))
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign tick = (r_cnt == ULTIMO) && !clear;

endmodule

// File: rtl/verificar_pin.sv
// ---------------------------------------------------------------------------
// verificar_pin
// Checks a submitted PIN against the stored master and user slots, pulses
// the result and counts consecutive failures.
// Build option: VERIFICAR_PIN_LOCKOUT_EN enables the timed lockout after
// MAX_TENTATIVAS consecutive failures; otherwise the failure count simply
// saturates and every submission is evaluated.
//   clk, rst        clock; asynchronous active-high reset
//   pin_in          assembled PIN; status 0->1 is a submission
//   setup           stored configuration
//   valid_user      one-cycle pulse, user PIN matched
//   valid_master    one-cycle pulse, master PIN matched
//   invalid_pin     one-cycle pulse, no match
//   bloqueado       high during lockout
//   tempo_restante  lockout seconds remaining
//   tentativas      consecutive-failure count
// Timing: digits captured in edge cycle E, setup compared in E+1,
// result pulse during E+2.
// ---------------------------------------------------------------------------
module verificar_pin
    import doorlock_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 1000,
    parameter int unsigned MAX_TENTATIVAS = 3,
    parameter int unsigned LOCKOUT_S      = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  pinPac_t    pin_in,
    input  setupPac_t  setup,
    output logic       valid_user,
    output logic       valid_master,
    output logic       invalid_pin,
    output logic       bloqueado,
    output logic [6:0] tempo_restante,
    output logic [2:0] tentativas
);

`ifdef VERIFICAR_PIN_LOCKOUT_EN
    typedef enum logic [1:0] {OCIOSO, COMPARAR, RESULTADO, BLOQUEADO} estado_t;
`else
    typedef enum logic [1:0] {OCIOSO, COMPARAR, RESULTADO} estado_t;
`endif

    localparam logic [2:0] MAX_T = 3'(MAX_TENTATIVAS);

    estado_t    r_estado;
    logic       r_status_ant;
    logic       r_armado;
    digitos_t   r_digitos;
    logic       r_valid_user;
    logic       r_valid_master;
    logic       r_invalid_pin;
    logic [2:0] r_tentativas;

    logic w_borda;
    logic w_master;
    logic w_user;

    // r_armado blocks the first cycle after reset so a status already high
    // at reset release is not mistaken for a fresh submission.
    assign w_borda  = pin_in.status && !r_status_ant && r_armado;
    assign w_master = slot_confere(setup.master_pin, r_digitos, 1'b0);
    assign w_user   = slot_confere(setup.pin1, r_digitos, 1'b1) ||
                      slot_confere(setup.pin2, r_digitos, 1'b1) ||
                      slot_confere(setup.pin3, r_digitos, 1'b1) ||
                      slot_confere(setup.pin4, r_digitos, 1'b1);

`ifdef VERIFICAR_PIN_LOCKOUT_EN
    logic       r_bloqueado;
    logic [6:0] r_tempo;
    logic       w_tick;

    gerador_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (r_estado != BLOQUEADO),
        .tick  (w_tick)
    );

    assign bloqueado      = r_bloqueado;
    assign tempo_restante = r_tempo;
`else
    assign bloqueado      = 1'b0;
    assign tempo_restante = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado       <= OCIOSO;
            r_status_ant   <= 1'b0;
            r_armado       <= 1'b0;
            r_digitos      <= '0;
            r_valid_user   <= 1'b0;
            r_valid_master <= 1'b0;
            r_invalid_pin  <= 1'b0;
            r_tentativas   <= '0;
`ifdef VERIFICAR_PIN_LOCKOUT_EN
            r_bloqueado    <= 1'b0;
            r_tempo        <= '0;
`endif
        end else begin
            r_status_ant   <= pin_in.status;
            r_armado       <= 1'b1;
            r_valid_user   <= 1'b0;
            r_valid_master <= 1'b0;
            r_invalid_pin  <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_borda) begin
                        r_digitos <= pin_in.digito;
                        r_estado  <= COMPARAR;
                    end
                end
                COMPARAR: begin
                    if (w_master)
                        r_valid_master <= 1'b1;
                    else if (w_user)
                        r_valid_user <= 1'b1;
                    else
                        r_invalid_pin <= 1'b1;
                    if (w_master || w_user)
                        r_tentativas <= '0;
                    else if (r_tentativas < MAX_T)
                        r_tentativas <= r_tentativas + 3'd1;
                    r_estado <= RESULTADO;
                end
`ifdef VERIFICAR_PIN_LOCKOUT_EN
                RESULTADO: begin
                    if (r_tentativas == MAX_T) begin
                        r_estado    <= BLOQUEADO;
                        r_bloqueado <= 1'b1;
                        r_tempo     <= 7'(LOCKOUT_S);
                    end else begin
                        r_estado <= OCIOSO;
                    end
                end
                BLOQUEADO: begin
                    if (w_tick) begin
                        if (r_tempo <= 7'd1) begin
                            r_tempo      <= '0;
                            r_bloqueado  <= 1'b0;
                            r_tentativas <= '0;
                            r_estado     <= OCIOSO;
                        end else begin
                            r_tempo <= r_tempo - 7'd1;
                        end
                    end
                end
`else
                // Without lockout a new edge here is accepted directly, so
                // back-to-back submissions are never dropped.
                RESULTADO: begin
                    if (w_borda) begin
                        r_digitos <= pin_in.digito;
                        r_estado  <= COMPARAR;
                    end else begin
                        r_estado <= OCIOSO;
                    end
                end
`endif
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign valid_user   = r_valid_user;
    assign valid_master = r_valid_master;
    assign invalid_pin  = r_invalid_pin;
    assign tentativas   = r_tentativas;

endmodule

// File: tb/tb_verificar_pin.sv
// ---------------------------------------------------------------------------
// tb_verificar_pin
// Directed bench for verificar_pin (CLK_FREQ_HZ=10, MAX_TENTATIVAS=3,
// LOCKOUT_S=3). Lockout expectations follow VERIFICAR_PIN_LOCKOUT_EN.
// ---------------------------------------------------------------------------
module tb_verificar_pin;
    import doorlock_pkg::*;

    localparam int unsigned CLK_HZ = 10;
    localparam int unsigned MAX_T  = 3;
    localparam int unsigned LOCK_S = 3;

    logic       clk = 1'b0;
    logic       rst;
    pinPac_t    pin_in;
    setupPac_t  setup;
    logic       valid_user, valid_master, invalid_pin, bloqueado;
    logic [6:0] tempo_restante;
    logic [2:0] tentativas;

    int n_total = 0;
    int n_bad   = 0;

    int         npulsos;
    logic       s_vu, s_vm, s_inv;
    logic [2:0] s_tent;

    always #5 clk = ~clk;

    verificar_pin #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .MAX_TENTATIVAS(MAX_T),
        .LOCKOUT_S     (LOCK_S)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pin_in        (pin_in),
        .setup         (setup),
        .valid_user    (valid_user),
        .valid_master  (valid_master),
        .invalid_pin   (invalid_pin),
        .bloqueado     (bloqueado),
        .tempo_restante(tempo_restante),
        .tentativas    (tentativas)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic digitos_t dg(input logic [3:0] a, input logic [3:0] b,
                                    input logic [3:0] c, input logic [3:0] d);
        return {a, b, c, d};
    endfunction

    function int pulsos_agora();
        return int'(valid_user) + int'(valid_master) + int'(invalid_pin);
    endfunction

    // Raise status with digits d (edge cycle E), scramble the digits after E,
    // sample results in E+2, return at E+3 with status low.
    task automatic submit(input digitos_t d);
        pin_in.digito = d;
        pin_in.status = 1'b1;
        npulsos = 0;
        step(1);
        pin_in.digito = dg(0, 0, 0, 0);
        npulsos += pulsos_agora();
        step(1);
        npulsos += pulsos_agora();
        s_vu   = valid_user;
        s_vm   = valid_master;
        s_inv  = invalid_pin;
        s_tent = tentativas;
        pin_in.status = 1'b0;
        step(1);
        npulsos += pulsos_agora();
    endtask

    task automatic chk_sub(input string tag, input logic evu, input logic evm,
                           input logic einv, input logic [2:0] etent);
        chk({tag, "_vu"},   32'(s_vu),   32'(evu));
        chk({tag, "_vm"},   32'(s_vm),   32'(evm));
        chk({tag, "_inv"},  32'(s_inv),  32'(einv));
        chk({tag, "_tent"}, 32'(s_tent), 32'(etent));
        chk({tag, "_np"},   32'(npulsos), 32'd1);
    endtask

    initial begin
        rst    = 1'b1;
        pin_in = '0;
        setup  = '0;
        setup.master_pin = '{status: 1'b0, digito: dg(9, 9, 9, 9)};
        setup.pin1       = '{status: 1'b1, digito: dg(9, 9, 9, 9)};
        setup.pin2       = '{status: 1'b1, digito: dg(1, 2, 3, 4)};
        setup.pin3       = '{status: 1'b0, digito: dg(5, 5, 5, 5)};
        setup.pin4       = '{status: 1'b1, digito: dg(7, 7, 7, PIN_DIGITO_VAZIO)};
        step(2);
        chk("rst_vu",    32'(valid_user),     32'd0);
        chk("rst_vm",    32'(valid_master),   32'd0);
        chk("rst_inv",   32'(invalid_pin),    32'd0);
        chk("rst_bloq",  32'(bloqueado),      32'd0);
        chk("rst_tempo", 32'(tempo_restante), 32'd0);
        chk("rst_tent",  32'(tentativas),     32'd0);
        rst = 1'b0;
        step(2);

        submit(dg(1, 2, 3, 4));  chk_sub("user2",    1, 0, 0, 0);
        submit(dg(5, 5, 5, 5));  chk_sub("disabled", 0, 0, 1, 1);
        submit(dg(7, 7, 7, 4'hE)); chk_sub("blank",  0, 0, 1, 2);
        submit(dg(1, 2, 3, 4));  chk_sub("clear",    1, 0, 0, 0);
        submit(dg(9, 9, 9, 9));  chk_sub("master",   0, 1, 0, 0);

        // status held high for five cycles: one result only
        pin_in.digito = dg(1, 2, 3, 4);
        pin_in.status = 1'b1;
        npulsos = 0;
        for (int i = 0; i < 5; i++) begin step(1); npulsos += pulsos_agora(); end
        pin_in.status = 1'b0;
        for (int i = 0; i < 3; i++) begin step(1); npulsos += pulsos_agora(); end
        chk("hold_np", 32'(npulsos), 32'd1);

        // status already high at reset release
        pin_in.status = 1'b1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        npulsos = 0;
        for (int i = 0; i < 5; i++) begin step(1); npulsos += pulsos_agora(); end
        chk("rsthigh_np", 32'(npulsos), 32'd0);
        pin_in.status = 1'b0;
        step(1);

        // reset in the middle of a compare
        submit(dg(0, 0, 0, 0));  chk_sub("zero", 0, 0, 1, 1);
        pin_in.digito = dg(1, 1, 1, 1);
        pin_in.status = 1'b1;
        step(1);
        rst = 1'b1;
        #1;
        chk("rstcmp_tent", 32'(tentativas), 32'd0);
        rst = 1'b0;
        npulsos = 0;
        for (int i = 0; i < 4; i++) begin step(1); npulsos += pulsos_agora(); end
        chk("rstcmp_np", 32'(npulsos), 32'd0);
        pin_in.status = 1'b0;
        step(1);

        submit(dg(1, 1, 1, 1));  chk_sub("wrong1", 0, 0, 1, 1);
        submit(dg(1, 1, 1, 1));  chk_sub("wrong2", 0, 0, 1, 2);
        submit(dg(1, 1, 1, 1));  chk_sub("wrong3", 0, 0, 1, 3);

`ifdef VERIFICAR_PIN_LOCKOUT_EN
        // now in E+3 of the third failure
        chk("lock_bloq",  32'(bloqueado),      32'd1);
        chk("lock_t3a",   32'(tempo_restante), 32'd3);
        submit(dg(9, 9, 9, 9));              // E+3..E+6, ignored
        chk("lock_np",    32'(npulsos), 32'd0);
        chk("lock_tent",  32'(tentativas), 32'd3);
        step(6);                             // E+12
        chk("lock_t3b",   32'(tempo_restante), 32'd3);
        step(1);                             // E+13
        chk("lock_t2",    32'(tempo_restante), 32'd2);
        step(10);                            // E+23
        chk("lock_t1",    32'(tempo_restante), 32'd1);
        step(9);                             // E+32
        chk("lock_t1b",   32'(tempo_restante), 32'd1);
        step(1);                             // E+33
        chk("lock_t0",    32'(tempo_restante), 32'd0);
        chk("lock_free",  32'(bloqueado),      32'd0);
        chk("lock_tent0", 32'(tentativas),     32'd0);
        submit(dg(1, 2, 3, 4));  chk_sub("after", 1, 0, 0, 0);

        // reset while locked out
        submit(dg(2, 2, 2, 2));
        submit(dg(2, 2, 2, 2));
        submit(dg(2, 2, 2, 2));
        step(5);
        chk("rstlock_pre", 32'(bloqueado), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstlock_bloq",  32'(bloqueado),      32'd0);
        chk("rstlock_tempo", 32'(tempo_restante), 32'd0);
        chk("rstlock_tent",  32'(tentativas),     32'd0);
        rst = 1'b0;
        step(2);
`else
        chk("nolock_bloq",  32'(bloqueado),      32'd0);
        chk("nolock_tempo", 32'(tempo_restante), 32'd0);
        submit(dg(1, 1, 1, 1));  chk_sub("sat",   0, 0, 1, 3);
        submit(dg(1, 2, 3, 4));  chk_sub("after", 1, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/verificar_pin.md
VERIFICAR_PIN -- requirements
Module: verificar_pin

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 1000: clk cycles per one-second tick.
REQ-002 Parameter MAX_TENTATIVAS, default 3: consecutive failures that trigger lockout (range 1..7).
REQ-003 Parameter LOCKOUT_S, default 30: lockout duration in seconds (range 1..99).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pin_in  input  pinPac_t  assembled PIN from the upstream PIN assembler; status high marks a submitted PIN.
REQ-007 setup  input  setupPac_t  stored configuration (master_pin, pin1..pin4).
REQ-008 valid_user  output  1  one-cycle pulse: a user PIN matched.
REQ-009 valid_master  output  1  one-cycle pulse: the master PIN matched.
REQ-010 invalid_pin  output  1  one-cycle pulse: no match.
REQ-011 bloqueado  output  1  level, high during lockout.
REQ-012 tempo_restante  output  7  lockout seconds remaining; 0 when not locked.
REQ-013 tentativas  output  3  current consecutive-failure count.

Function
REQ-014 The block SHALL register pin_in.status and treat only a 0->1 transition as a submission; status remaining high for further cycles SHALL NOT cause resubmission.
REQ-015 On the edge cycle E the block SHALL capture pin_in digits; setup SHALL be sampled at E+1; exactly one result pulse SHALL be high during cycle E+2.
REQ-016 Slot match: all four digits equal, and every stored digit <= 9; a slot containing any digit > 9 (e.g. blank 4'hE) SHALL never match.
REQ-017 master_pin SHALL be compared regardless of its status bit; pin1..pin4 SHALL match only when their status bit is 1.
REQ-018 Priority: master match -> valid_master only; else any user match -> valid_user; else invalid_pin.
REQ-019 Any valid result SHALL clear tentativas to 0; invalid SHALL increment tentativas.
REQ-020 FSM states: OCIOSO (wait edge), COMPARAR (compare), RESULTADO (pulse, update count), BLOQUEADO (countdown).
REQ-021 Transitions: OCIOSO->COMPARAR on edge; COMPARAR->RESULTADO unconditionally; RESULTADO->BLOQUEADO if tentativas reaches MAX_TENTATIVAS, else ->OCIOSO; BLOQUEADO->OCIOSO when tempo_restante reaches 0.
REQ-022 Entering BLOQUEADO: bloqueado=1 and tempo_restante=LOCKOUT_S in the cycle after the invalid_pin pulse; prescaler restarted.
REQ-023 In BLOQUEADO tempo_restante SHALL decrement once every CLK_FREQ_HZ cycles; on reaching 0: bloqueado=0, tentativas=0, state OCIOSO in the same cycle.
REQ-024 Submissions arriving in COMPARAR, RESULTADO or BLOQUEADO (including master PIN) SHALL be ignored with no pulse and no count change.
REQ-025 tentativas SHALL never exceed MAX_TENTATIVAS.

Reset
REQ-026 rst SHALL force state OCIOSO, all pulses 0, bloqueado 0, tempo_restante 0, tentativas 0, prescaler 0, status history 0, including mid-lockout or mid-compare.
REQ-027 A pin_in.status already high when rst deasserts SHALL NOT count as a submission.

Configuration
REQ-028 Macro VERIFICAR_PIN_LOCKOUT_EN: when defined, REQ-020..REQ-024 lockout behaviour applies.
REQ-029 When undefined: no BLOQUEADO state, bloqueado and tempo_restante tied to 0, tentativas saturates at MAX_TENTATIVAS, every submission is evaluated.

Structure
REQ-030 pinPac_t and setupPac_t SHALL reside in shared package doorlock_pkg along with constant PIN_DIGITO_VAZIO = 4'hE.
REQ-031 The one-second prescaler SHALL be a sub-module gerador_tick (parameter CLK_FREQ_HZ, inputs clk, rst, clear; output tick pulse).

Verification
REQ-032 setup.pin2 = 1-2-3-4 status 1; submit 1-2-3-4 -> valid_user pulse at E+2, tentativas=0.
REQ-033 master 9-9-9-9, pin1 also 9-9-9-9 status 1; submit 9-9-9-9 -> valid_master only, valid_user stays 0.
REQ-034 pin3 = 5-5-5-5 status 0; submit 5-5-5-5 -> invalid_pin, tentativas=1.
REQ-035 CLK_FREQ_HZ=10, LOCKOUT_S=3: three wrong PINs -> bloqueado=1, tempo_restante 3,2,1,0 at 10-cycle intervals; correct PIN during lockout -> no pulse; after expiry correct PIN -> valid_user.
REQ-036 status held high 5 cycles -> exactly one result pulse; rst asserted during BLOQUEADO -> bloqueado=0, tempo_restante=0, tentativas=0 immediately.
